// File: rtl/full_adder.sv
// full_adder: registered WIDTH-bit adder a + b + cin, one-cycle latency.
// The core is WIDTH/4 four-bit carry-lookahead groups with the group
// carries rippled from each group to the next.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset; clears all outputs
//   in_valid  a/b/cin carry an operation this cycle
//   a, b      unsigned operands, WIDTH bits
//   cin       carry into bit 0
//   sum       registered a+b+cin modulo 2^WIDTH
//   c_out     registered carry out of bit WIDTH-1
//   overflow  registered two's-complement signed overflow
//   out_valid one-cycle pulse aligned with each registered result

// One 4-bit lookahead group: carries to every bit come from p/g and the
// group carry-in directly, so there is no ripple inside the group.
module full_adder_cla4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] c;

  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end
endmodule

module full_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             out_valid
);
  localparam int NUM_GRP = WIDTH / 4;

  logic [NUM_GRP-1:0][3:0] p_grp;
  logic [NUM_GRP-1:0][3:0] g_grp;
  logic [NUM_GRP-1:0][3:0] s_grp;
  logic [NUM_GRP:0]        gc;     // carry into each group; gc[NUM_GRP] is c_out
  logic [WIDTH-1:0]        s_nxt;
  logic                    ov_nxt;

  // Packed group arrays share the flat bit order of the operands.
  assign p_grp = a ^ b;
  assign g_grp = a & b;
  assign gc[0] = cin;

  for (genvar i = 0; i < NUM_GRP; i++) begin : g_grp_inst
    full_adder_cla4 u_cla4 (
      .p  (p_grp[i]),
      .g  (g_grp[i]),
      .ci (gc[i]),
      .s  (s_grp[i]),
      .co (gc[i+1])
    );
  end

  assign s_nxt  = s_grp;
  // Like-signed operands whose result sign differs from them.
  assign ov_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (s_nxt[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Results hold across idle cycles.
      if (in_valid) begin
        sum      <= s_nxt;
        c_out    <= gc[NUM_GRP];
        overflow <= ov_nxt;
      end
    end
  end
endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp32_t;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv32, ci32, co32, ov32, v32;
  logic [31:0] a32, b32, s32;
  logic        iv8, ci8, co8, ov8, v8;
  logic [7:0]  a8, b8, s8;

  int tests = 0;
  int fails = 0;

  exp32_t q32[$];
  exp8_t  q8[$];
  exp32_t m32;
  exp8_t  m8;
  logic   ev32, ev8;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .a(a32), .b(b32), .cin(ci32),
    .sum(s32), .c_out(co32), .overflow(ov32), .out_valid(v32)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(ci8),
    .sum(s8), .c_out(co8), .overflow(ov8), .out_valid(v8)
  );

  function automatic exp32_t ref32(logic [31:0] a, logic [31:0] b, logic c);
    logic [32:0] t;
    exp32_t r;
    t   = {1'b0, a} + {1'b0, b} + {32'd0, c};
    r.s = t[31:0];
    r.c = t[32];
    r.o = (a[31] == b[31]) && (t[31] != a[31]);
    return r;
  endfunction

  function automatic exp8_t ref8(logic [7:0] a, logic [7:0] b, logic c);
    logic [8:0] t;
    exp8_t r;
    t   = {1'b0, a} + {1'b0, b} + {8'd0, c};
    r.s = t[7:0];
    r.c = t[8];
    r.o = (a[7] == b[7]) && (t[7] != a[7]);
    return r;
  endfunction

  task automatic chk32(string tag);
    if (ev32) begin
      if (q32.size() == 0) begin
        fails++;
        $error("FAIL %s w32 scoreboard empty", tag);
      end else m32 = q32.pop_front();
    end
    tests++;
    assert (v32 === ev32) else begin
      fails++; $error("FAIL %s w32 out_valid got %b exp %b", tag, v32, ev32);
    end
    tests++;
    assert (s32 === m32.s) else begin
      fails++; $error("FAIL %s w32 sum got %h exp %h", tag, s32, m32.s);
    end
    tests++;
    assert (co32 === m32.c) else begin
      fails++; $error("FAIL %s w32 c_out got %b exp %b", tag, co32, m32.c);
    end
    tests++;
    assert (ov32 === m32.o) else begin
      fails++; $error("FAIL %s w32 overflow got %b exp %b", tag, ov32, m32.o);
    end
  endtask

  task automatic chk8(string tag);
    if (ev8) begin
      if (q8.size() == 0) begin
        fails++;
        $error("FAIL %s w8 scoreboard empty", tag);
      end else m8 = q8.pop_front();
    end
    tests++;
    assert (v8 === ev8) else begin
      fails++; $error("FAIL %s w8 out_valid got %b exp %b", tag, v8, ev8);
    end
    tests++;
    assert (s8 === m8.s) else begin
      fails++; $error("FAIL %s w8 sum got %h exp %h", tag, s8, m8.s);
    end
    tests++;
    assert (co8 === m8.c) else begin
      fails++; $error("FAIL %s w8 c_out got %b exp %b", tag, co8, m8.c);
    end
    tests++;
    assert (ov8 === m8.o) else begin
      fails++; $error("FAIL %s w8 overflow got %b exp %b", tag, ov8, m8.o);
    end
  endtask

  // Drive one cycle on both DUTs, push expectations, clock, then check.
  task automatic step(input logic rst, input logic v32i, input logic [31:0] a32i,
                      input logic [31:0] b32i, input logic c32i, input logic v8i,
                      input logic [7:0] a8i, input logic [7:0] b8i, input logic c8i,
                      input string tag);
    rst_n = rst;
    iv32 = v32i; a32 = a32i; b32 = b32i; ci32 = c32i;
    iv8  = v8i;  a8  = a8i;  b8  = b8i;  ci8  = c8i;
    if (!rst) begin
      q32.delete(); q8.delete();
      m32 = '0; m8 = '0;
      ev32 = 1'b0; ev8 = 1'b0;
    end else begin
      ev32 = v32i;
      ev8  = v8i;
      if (v32i) q32.push_back(ref32(a32i, b32i, c32i));
      if (v8i)  q8.push_back(ref8(a8i, b8i, c8i));
    end
    @(posedge clk);
    #1;
    chk32(tag);
    chk8(tag);
  endtask

  initial begin
    m32 = '0; m8 = '0; ev32 = 1'b0; ev8 = 1'b0;
    rst_n = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0;
    iv8  = 1'b0; a8  = '0; b8  = '0; ci8  = 1'b0;
    #2;

    step(1'b0, 1'b1, 32'h1234, 32'h1, 1'b1, 1'b1, 8'h12, 8'h1, 1'b1, "reset1");
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, "reset2");

    // First valid edge after reset gives a result immediately.
    step(1'b1, 1'b1, 32'd1, 32'd2, 1'b1, 1'b1, 8'd1, 8'd2, 1'b1, "simple");
    step(1'b1, 1'b1, 32'd10, 32'd20, 1'b0, 1'b1, 8'd10, 8'd20, 1'b0, "b2b_a");
    step(1'b1, 1'b1, 32'd55, 32'd66, 1'b1, 1'b1, 8'd55, 8'd66, 1'b1, "b2b_b");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 8'hFF, 8'h0, 1'b1, "wrap0");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "allones");
    step(1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 8'h7F, 8'h1, 1'b0, "pos_ovf");
    step(1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 8'h80, 8'h80, 1'b0, "neg_ovf");
    step(1'b1, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1, "group_chain");

    // Idle cycles: outputs hold, out_valid low (inputs wiggle to catch leaks).
    step(1'b1, 1'b0, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0, 8'hDE, 8'h1, 1'b1, "hold1");
    step(1'b1, 1'b0, 32'h12345678, 32'h9, 1'b0, 1'b0, 8'h12, 8'h9, 1'b0, "hold2");
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h0, 8'h0, 1'b1, "hold3");

    // Reset with an operation present: discarded, never emerges.
    step(1'b0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 8'h7F, 8'h7F, 1'b1, "rst_prio");
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0, "post_rst");

    for (int i = 0; i < 10000; i++) begin
      step(1'b1, ($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
           ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
           "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand and sum width in bits; legal range 4..64, multiple of 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  high when a, b and cin carry an operation to register this cycle.
REQ-005 a  input  WIDTH  first unsigned operand.
REQ-006 b  input  WIDTH  second unsigned operand.
REQ-007 cin  input  1  carry into bit 0.
REQ-008 sum  output  WIDTH  registered result bits [WIDTH-1:0] of a+b+cin.
REQ-009 c_out  output  1  registered carry out of bit WIDTH-1.
REQ-010 overflow  output  1  registered two's-complement signed overflow flag for the same operation.
REQ-011 out_valid  output  1  high for exactly one cycle per accepted operation, aligned with its sum/c_out/overflow.

Function
REQ-012 Arithmetic: {c_out, sum} SHALL equal the (WIDTH+1)-bit zero-extended value a + b + cin; no saturation, sum wraps modulo 2^WIDTH.
REQ-013 overflow SHALL be 1 iff a[WIDTH-1] == b[WIDTH-1] and sum[WIDTH-1] != a[WIDTH-1]; otherwise 0.
REQ-014 Adder core: per-bit propagate p=a^b and generate g=a&b, organised as WIDTH/4 carry-lookahead groups of 4 bits, group carries rippled group to group; sum bit = p ^ carry-in of that bit.
REQ-015 The combinational core SHALL be built from explicit p/g/carry logic, not a single vector '+' operator, so the group structure is visible for timing review.
REQ-016 Latency: a, b, cin sampled at rising edge N with in_valid=1 SHALL appear on sum, c_out, overflow with out_valid=1 after that same edge N (one-cycle latency, fully pipelined, one new operation per cycle).
REQ-017 in_valid=0 at an edge: out_valid SHALL be 0 after that edge; sum, c_out and overflow SHALL hold their previous values.
REQ-018 Back-to-back operations: consecutive in_valid cycles SHALL produce consecutive out_valid cycles, each with its own result; no stall, no backpressure input.
REQ-019 Inputs containing X/Z are outside the contract; no checking logic is required.
REQ-020 No combinational path from any input to any output; all outputs come directly from flops.

Reset
REQ-021 rst_n=0 at a rising edge SHALL force sum=0, c_out=0, overflow=0, out_valid=0 after that edge, regardless of in_valid.
REQ-022 Reset has priority over in_valid: an operation presented in a reset cycle is discarded and never produces out_valid.
REQ-023 First edge with rst_n=1 and in_valid=1 SHALL produce a normal result after that edge; no extra recovery cycle.
REQ-024 Outputs before the first reset edge are undefined; the bench SHALL apply reset for at least 2 cycles before checking.

Verification
REQ-025 a=1, b=2, cin=1, in_valid=1 -> next cycle sum=4, c_out=0, overflow=0, out_valid=1.
REQ-026 Back-to-back a=10,b=20,cin=0 then a=55,b=66,cin=1 -> sum=30 then sum=122 on consecutive cycles, c_out=0, out_valid=1 both cycles.
REQ-027 a=0xFFFFFFFF, b=0, cin=1 -> sum=0, c_out=1, overflow=0; a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, c_out=1.
REQ-028 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, overflow=1, c_out=0; a=0x80000000, b=0x80000000, cin=0 -> sum=0, c_out=1, overflow=1.
REQ-029 Result present, then in_valid=0 for 3 cycles -> out_valid=0, sum/c_out/overflow unchanged; then rst_n=0 with in_valid=1 -> all outputs 0, no out_valid.
REQ-030 Randomised: 10,000 random a, b, cin with random in_valid compared against a WIDTH+1-bit reference sum, for WIDTH=32 and WIDTH=8.
